// File: rtl/ila_readout_ctrl_if.sv
// Valid/ready stream that carries ila_core buffer words out of ila_readout_ctrl.
interface ila_readout_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ila_readout_ctrl.sv
// Clear/capture/readout sequencer for one ila_core; streams the buffer sample-major, word 0 first.
// Optional ARM-state capture timeout is enabled by defining ILA_RDCTRL_TIMEOUT_EN.
module ila_readout_ctrl #(
    parameter  int DATA_W    = 32,
    parameter  int BUFFER_W  = 8,
    parameter  int SIGNAL_W  = 64,
    parameter  int TIMEOUT_W = 16,
    localparam int N_WORDS   = (SIGNAL_W + DATA_W - 1) / DATA_W,
    localparam int SEL_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BUFFER_W-1:0]  n_samples,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic [BUFFER_W-1:0]  ila_samples,
    input  logic [DATA_W-1:0]    ila_value,
    output logic [BUFFER_W-1:0]  ila_index,
    output logic [SEL_W-1:0]     ila_value_select,
    output logic                 ila_rst_soft,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    ila_readout_ctrl_if.master   m_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_ADDR, S_FETCH, S_SEND, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [BUFFER_W-1:0] r_n_req, r_idx, r_index;
    logic [SEL_W-1:0]    r_word, r_sel;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_valid, r_m_last, r_timed_out;

    logic                w_samples_ok, w_timeout, w_arm_timeout;
    logic                w_word_wrap, w_last_word;
    logic [BUFFER_W-1:0] w_idx_nxt;
    logic [SEL_W-1:0]    w_word_nxt;

    assign w_samples_ok  = (ila_samples >= r_n_req);
    assign w_arm_timeout = (r_n_req != '0) && !w_samples_ok && w_timeout;
    assign w_word_wrap   = (r_word == SEL_W'(N_WORDS - 1));
    assign w_last_word   = (r_idx == r_n_req - 1'b1) && w_word_wrap;
    assign w_word_nxt    = w_word_wrap ? '0 : r_word + 1'b1;
    assign w_idx_nxt     = w_word_wrap ? r_idx + 1'b1 : r_idx;

`ifdef ILA_RDCTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_lim, r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_lim <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && start && !abort)
                r_tmo_lim <= timeout_lim;
            r_tmo_cnt <= (r_state == S_ARM) ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    // A zero limit disables the timeout; the count cannot wrap before a nonzero limit is hit.
    assign w_timeout = (r_tmo_lim != '0) && (r_tmo_cnt == r_tmo_lim);
`else
    logic w_unused_timeout_lim;
    assign w_unused_timeout_lim = ^timeout_lim;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_ARM;
            S_ARM: begin
                if (r_n_req == '0)
                    w_state_nxt = S_DONE;
                else if (w_samples_ok)
                    w_state_nxt = S_ADDR;
                else if (w_arm_timeout)
                    w_state_nxt = (ila_samples == '0) ? S_DONE : S_ADDR;
            end
            S_ADDR:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_SEND;
            S_SEND:  if (m_if.m_ready) w_state_nxt = r_m_last ? S_DONE : S_ADDR;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort)
            w_state_nxt = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_req     <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_index     <= '0;
            r_sel       <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (abort) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) r_n_req <= n_samples;
                S_CLEAR: begin
                    r_idx       <= '0;
                    r_word      <= '0;
                    r_timed_out <= 1'b0;
                end
                S_ARM: begin
                    if (w_arm_timeout) begin
                        r_n_req     <= ila_samples;
                        r_timed_out <= 1'b1;
                    end
                    if (w_state_nxt == S_ADDR) begin
                        r_index <= r_idx;
                        r_sel   <= r_word;
                    end
                end
                S_FETCH: begin
                    r_m_data  <= ila_value;
                    r_m_valid <= 1'b1;
                    r_m_last  <= w_last_word;
                end
                S_SEND: begin
                    if (m_if.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        // Address moves on the handshake so the core has ADDR+FETCH to settle.
                        if (!r_m_last) begin
                            r_idx   <= w_idx_nxt;
                            r_word  <= w_word_nxt;
                            r_index <= w_idx_nxt;
                            r_sel   <= w_word_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ila_index        = r_index;
    assign ila_value_select = r_sel;
    assign ila_rst_soft     = (r_state == S_CLEAR);
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign timed_out        = r_timed_out;
    assign m_if.m_valid     = r_m_valid;
    assign m_if.m_data      = r_m_data;
    assign m_if.m_last      = r_m_last;

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Bench for ila_readout_ctrl: a 2-word (SIGNAL_W=64) and a 1-word (SIGNAL_W=8) instance
// driven against behavioural ila_core models and a queue of expected stream words.
module tb_ila_readout_ctrl;
    localparam int DATA_W    = 32;
    localparam int BUFFER_W  = 8;
    localparam int TIMEOUT_W = 16;
    localparam int DEPTH     = 1 << BUFFER_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                sel;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, abort, sel_narrow, m_ready;
    logic [BUFFER_W-1:0]  n_samples;
    logic [TIMEOUT_W-1:0] timeout_lim;
    int                   cap_tgt;
    int                   total = 0;
    int                   bad   = 0;
    logic [63:0]          mem64 [DEPTH];
    logic [7:0]           mem8  [DEPTH];
    word_t                exp_q [$];

    logic [BUFFER_W-1:0] samples_w, index_w, samples_n, index_n;
    logic [DATA_W-1:0]   value_w, value_n;
    logic                sel_w, sel_n, start_w, start_n;
    logic                rst_soft_w, busy_w, done_w, tmo_w;
    logic                rst_soft_n, busy_n, done_n, tmo_n;

    ila_readout_ctrl_if #(.DATA_W(DATA_W)) if_w ();
    ila_readout_ctrl_if #(.DATA_W(DATA_W)) if_n ();

    assign start_w      = start & ~sel_narrow;
    assign start_n      = start & sel_narrow;
    assign if_w.m_ready = m_ready;
    assign if_n.m_ready = m_ready;

    ila_readout_ctrl #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .SIGNAL_W(64), .TIMEOUT_W(TIMEOUT_W)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .abort(abort), .n_samples(n_samples),
        .timeout_lim(timeout_lim), .ila_samples(samples_w), .ila_value(value_w),
        .ila_index(index_w), .ila_value_select(sel_w), .ila_rst_soft(rst_soft_w),
        .busy(busy_w), .done(done_w), .timed_out(tmo_w), .m_if(if_w));

    ila_readout_ctrl #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .SIGNAL_W(8), .TIMEOUT_W(TIMEOUT_W)) dut_n (
        .clk(clk), .rst(rst), .start(start_n), .abort(abort), .n_samples(n_samples),
        .timeout_lim(timeout_lim), .ila_samples(samples_n), .ila_value(value_n),
        .ila_index(index_n), .ila_value_select(sel_n), .ila_rst_soft(rst_soft_n),
        .busy(busy_n), .done(done_n), .timed_out(tmo_n), .m_if(if_n));

    // Core models: capture counter restarts on rst_soft and climbs to cap_tgt; value is registered.
    always @(posedge clk) begin
        if (rst || rst_soft_w)                samples_w <= '0;
        else if (int'(samples_w) < cap_tgt)   samples_w <= samples_w + 1'b1;
        if (rst || rst_soft_n)                samples_n <= '0;
        else if (int'(samples_n) < cap_tgt)   samples_n <= samples_n + 1'b1;
        value_w <= mem64[index_w][int'(sel_w)*DATA_W +: DATA_W];
        value_n <= {24'b0, mem8[index_n]};
    end

    logic              o_valid, o_last, o_busy, o_done, o_rst_soft, o_tmo, o_sel;
    logic [DATA_W-1:0] o_data;
    assign o_valid    = sel_narrow ? if_n.m_valid : if_w.m_valid;
    assign o_last     = sel_narrow ? if_n.m_last  : if_w.m_last;
    assign o_data     = sel_narrow ? if_n.m_data  : if_w.m_data;
    assign o_busy     = sel_narrow ? busy_n       : busy_w;
    assign o_done     = sel_narrow ? done_n       : done_w;
    assign o_rst_soft = sel_narrow ? rst_soft_n   : rst_soft_w;
    assign o_tmo      = sel_narrow ? tmo_n        : tmo_w;
    assign o_sel      = sel_narrow ? sel_n        : sel_w;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input bit narrow, input int n);
        int nw = narrow ? 1 : 2;
        exp_q.delete();
        for (int i = 0; i < n; i++)
            for (int w = 0; w < nw; w++) begin
                word_t e;
                e.data = narrow ? {24'b0, mem8[i]} : mem64[i][w*DATA_W +: DATA_W];
                e.last = (i == n - 1) && (w == nw - 1);
                e.sel  = w;
                exp_q.push_back(e);
            end
    endtask

    task automatic run_readout(input bit narrow, input int n, input int n_exp, input int tgt,
                               input int lim, input int ready_pct, input int stall_word,
                               input int stall_len, input bit exp_tmo);
        int nw = narrow ? 1 : 2;
        int words = 0, last_hs = -100, done_cyc = -1, stall_left = stall_len;
        bit pv = 0, phs = 0, any_valid = 0;
        logic [DATA_W-1:0] pd = '0;
        logic pl = 1'b0;
        sel_narrow = narrow;
        cap_tgt    = tgt;
        m_ready    = 1'b0;
        build_expected(narrow, n_exp);
        @(negedge clk);
        n_samples = BUFFER_W'(n); timeout_lim = TIMEOUT_W'(lim); start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_samples = BUFFER_W'($urandom);
        check("clear_pulse", o_rst_soft, 1);
        check("busy_after_start", o_busy, 1);
        for (int cyc = 1; cyc < 4000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("clear_one_cycle", o_rst_soft, 0);
            if (o_valid && words == stall_word && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = ($urandom_range(99) < ready_pct);
            end
            if (pv && !phs) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, pd);
                check("hold_last", o_last, pl);
            end
            any_valid |= o_valid;
            if (o_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    word_t e = exp_q.pop_front();
                    check("data", o_data, e.data);
                    check("last", o_last, e.last);
                    check("value_select", o_sel, e.sel);
                end
                if (ready_pct == 100 && stall_len == 0 && words > 0)
                    check("throughput_gap", cyc - last_hs, 3);
                last_hs = cyc;
                words++;
            end
            if (o_done) done_cyc = cyc;
            pv = o_valid; phs = o_valid && m_ready; pd = o_data; pl = o_last;
        end
        m_ready = 1'b0;
        if (done_cyc < 0) begin
            check("done_within_budget", 0, 1);
        end else begin
            check("queue_drained", exp_q.size(), 0);
            check("word_count", words, n_exp * nw);
            if (n == 0) begin
                check("done_latency_empty", done_cyc, 2);
                check("no_valid_empty", any_valid, 0);
            end else begin
                check("done_after_last", done_cyc - last_hs, 1);
            end
            check("timed_out", o_tmo, exp_tmo);
            @(negedge clk);
            check("done_one_cycle", o_done, 0);
            check("idle_after_done", o_busy, 0);
        end
    endtask

    initial begin
        bit seen, any_done, all_busy, any_valid;
        rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; sel_narrow = 1'b0;
        n_samples = '0; timeout_lim = '0; cap_tgt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem64[i] = {$urandom, $urandom};
            mem8[i]  = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        check("rst_valid_w", if_w.m_valid, 0);
        check("rst_last_w", if_w.m_last, 0);
        check("rst_data_w", if_w.m_data, 0);
        check("rst_busy_w", busy_w, 0);
        check("rst_done_w", done_w, 0);
        check("rst_soft_w", rst_soft_w, 0);
        check("rst_index_w", index_w, 0);
        check("rst_sel_w", sel_w, 0);
        check("rst_tmo_w", tmo_w, 0);
        check("rst_valid_n", if_n.m_valid, 0);
        check("rst_busy_n", busy_n, 0);
        rst = 1'b0;

        // Narrow core, samples 2,7,9, always ready.
        mem8[0] = 8'd2; mem8[1] = 8'd7; mem8[2] = 8'd9;
        run_readout(1, 3, 3, 5, 0, 100, -1, 0, 0);

        // Two-word samples {0x2,0x1},{0x5,0x4}.
        mem64[0] = {32'h2, 32'h1}; mem64[1] = {32'h5, 32'h4};
        run_readout(0, 2, 2, 2, 0, 100, -1, 0, 0);

        // Backpressure: ready held low 4 cycles while word 1 is presented.
        run_readout(0, 2, 2, 4, 0, 100, 1, 4, 0);

        // Empty request.
        run_readout(0, 0, 0, 0, 0, 100, -1, 0, 0);

        // Random contents, lengths and ready patterns on both widths.
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < DEPTH; i++) begin
                mem64[i] = {$urandom, $urandom};
                mem8[i]  = 8'($urandom);
            end
            run_readout(k[0], n, n, n + $urandom_range(0, 5), 0, $urandom_range(30, 90), -1, 0, 0);
        end

        // Largest request the index can express.
        run_readout(1, DEPTH - 1, DEPTH - 1, DEPTH - 1, 0, 100, -1, 0, 0);

        // Abort while a word is waiting for ready.
        sel_narrow = 1'b0; cap_tgt = 20; m_ready = 1'b0;
        @(negedge clk); n_samples = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = o_valid;
        end
        check("abort_valid_seen", seen, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_valid", o_valid, 0);
        check("abort_last", o_last, 0);
        check("abort_busy", o_busy, 0);
        check("abort_rst_soft", o_rst_soft, 0);
        any_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any_done |= o_done;
        end
        check("abort_no_done", any_done, 0);
        run_readout(0, 3, 3, 20, 0, 70, -1, 0, 0);

        // Start and abort together: start is dropped.
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("abort_beats_start_busy", o_busy, 0);
        check("abort_beats_start_clear", o_rst_soft, 0);

        // Core stuck at one captured sample.
`ifdef ILA_RDCTRL_TIMEOUT_EN
        run_readout(1, 4, 1, 1, 10, 100, -1, 0, 1);
`else
        sel_narrow = 1'b1; cap_tgt = 1;
        @(negedge clk); n_samples = 8'd4; timeout_lim = 16'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        all_busy = 1; any_valid = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            all_busy  &= o_busy;
            any_valid |= o_valid;
        end
        check("stuck_busy", all_busy, 1);
        check("stuck_no_valid", any_valid, 0);
        check("stuck_no_timeout", o_tmo, 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_from_arm", o_busy, 0);
`endif

        // Reset in the middle of a readout.
        sel_narrow = 1'b0; cap_tgt = 5; m_ready = 1'b0;
        @(negedge clk); n_samples = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = o_valid;
        end
        check("midrst_valid_seen", seen, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", if_w.m_valid, 0);
        check("midrst_busy", busy_w, 0);
        check("midrst_index", index_w, 0);
        @(negedge clk); rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
